// File: rtl/cp_bypass_ctrl.sv
// Hazard detection and bypass-select generation for the CP pipeline.
// Tracks the ID-stage writer and compares it with the IF-stage sources one cycle ahead.
module cp_bypass_ctrl #(
  parameter int unsigned RF_INDEX_WIDTH = 5,
  parameter int unsigned MUL_LATENCY    = 1,
  parameter int unsigned LSU_LATENCY    = 2,
  parameter int unsigned SHADOW_INDEX   = 31
) (
  input  logic                      iClk,
  input  logic                      iReset_n,
  input  logic                      iStall,
  input  logic                      iFlush,
  input  logic                      iIF_Valid,
  input  logic [RF_INDEX_WIDTH-1:0] iIF_RF_Read_Addr_A,
  input  logic [RF_INDEX_WIDTH-1:0] iIF_RF_Read_Addr_B,
  input  logic                      iIF_Read_En_A,
  input  logic                      iIF_Read_En_B,
  input  logic                      iIF_Write_En,
  input  logic [RF_INDEX_WIDTH-1:0] iIF_RF_Write_Addr,
  input  logic [1:0]                iIF_Result_Src,
  output logic                      oIF_BP_Bypass_Read_A,
  output logic                      oIF_BP_Bypass_Read_B,
  output logic [1:0]                oIF_BP_Bypass_Sel_A,
  output logic [1:0]                oIF_BP_Bypass_Sel_B,
  output logic                      oHazard_Stall,
  output logic                      oID_Write_Valid,
  output logic [RF_INDEX_WIDTH-1:0] oID_RF_Write_Addr
);

  localparam logic [1:0] SRC_ALU    = 2'd0;
  localparam logic [1:0] SRC_MUL    = 2'd1;
  localparam logic [1:0] SRC_LSU    = 2'd2;
  localparam logic [1:0] SRC_SHADOW = 2'd3;

  localparam logic [RF_INDEX_WIDTH-1:0] SHADOW_ADDR = RF_INDEX_WIDTH'(SHADOW_INDEX);
  localparam logic [RF_INDEX_WIDTH-1:0] ZERO_ADDR   = '0;

  localparam logic MUL_IS_LATE = (MUL_LATENCY == 32'd2);
  localparam logic LSU_IS_LATE = (LSU_LATENCY == 32'd2);

  // ID slot: the instruction one cycle ahead of IF.
  logic                      r_id_valid;
  logic [RF_INDEX_WIDTH-1:0] r_id_dest;
  logic [1:0]                r_id_src;

  logic                      r_bp_read_a;
  logic                      r_bp_read_b;
  logic [1:0]                r_bp_sel_a;
  logic [1:0]                r_bp_sel_b;

  logic [1:0]                w_src_eff;
  logic                      w_match_a;
  logic                      w_match_b;
  logic                      w_id_late;
  logic                      w_hazard;
  logic                      w_if_writes;

  always_comb begin
    w_src_eff = (iIF_RF_Write_Addr == SHADOW_ADDR) ? SRC_SHADOW : iIF_Result_Src;

    w_match_a = iIF_Valid & iIF_Read_En_A & r_id_valid &
                (r_id_dest == iIF_RF_Read_Addr_A) & (iIF_RF_Read_Addr_A != ZERO_ADDR);
    w_match_b = iIF_Valid & iIF_Read_En_B & r_id_valid &
                (r_id_dest == iIF_RF_Read_Addr_B) & (iIF_RF_Read_Addr_B != ZERO_ADDR);

    // Shadow and ALU results are always ready at the EX bypass point.
    w_id_late = ((r_id_src == SRC_MUL) & MUL_IS_LATE) |
                ((r_id_src == SRC_LSU) & LSU_IS_LATE);

    w_hazard    = (w_match_a | w_match_b) & w_id_late & ~iFlush;
    w_if_writes = iIF_Valid & iIF_Write_En & (iIF_RF_Write_Addr != ZERO_ADDR);
  end

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      r_id_valid  <= 1'b0;
      r_id_dest   <= '0;
      r_id_src    <= SRC_ALU;
      r_bp_read_a <= 1'b0;
      r_bp_read_b <= 1'b0;
      r_bp_sel_a  <= SRC_ALU;
      r_bp_sel_b  <= SRC_ALU;
    end else if (iFlush) begin
      r_id_valid  <= 1'b0;
      r_id_dest   <= '0;
      r_id_src    <= SRC_ALU;
      r_bp_read_a <= 1'b0;
      r_bp_read_b <= 1'b0;
      r_bp_sel_a  <= SRC_ALU;
      r_bp_sel_b  <= SRC_ALU;
    end else if (iStall) begin
      r_id_valid  <= r_id_valid;
      r_id_dest   <= r_id_dest;
      r_id_src    <= r_id_src;
      r_bp_read_a <= r_bp_read_a;
      r_bp_read_b <= r_bp_read_b;
      r_bp_sel_a  <= r_bp_sel_a;
      r_bp_sel_b  <= r_bp_sel_b;
    end else if (w_hazard) begin
      // Bubble into ID; IF re-presents the consumer while the producer reaches WB.
      r_id_valid  <= 1'b0;
      r_id_dest   <= '0;
      r_id_src    <= SRC_ALU;
      r_bp_read_a <= 1'b0;
      r_bp_read_b <= 1'b0;
      r_bp_sel_a  <= SRC_ALU;
      r_bp_sel_b  <= SRC_ALU;
    end else begin
      r_id_valid  <= w_if_writes;
      r_id_dest   <= iIF_RF_Write_Addr;
      r_id_src    <= w_src_eff;
      r_bp_read_a <= w_match_a;
      r_bp_read_b <= w_match_b;
      r_bp_sel_a  <= w_match_a ? r_id_src : SRC_ALU;
      r_bp_sel_b  <= w_match_b ? r_id_src : SRC_ALU;
    end
  end

  assign oIF_BP_Bypass_Read_A = r_bp_read_a;
  assign oIF_BP_Bypass_Read_B = r_bp_read_b;
  assign oIF_BP_Bypass_Sel_A  = r_bp_sel_a;
  assign oIF_BP_Bypass_Sel_B  = r_bp_sel_b;
  assign oHazard_Stall        = w_hazard;
  assign oID_Write_Valid      = r_id_valid;
  assign oID_RF_Write_Addr    = r_id_dest;

endmodule

// File: doc/cp_bypass_ctrl.md
Name: cp_bypass_ctrl

Overview:
- Hazard-detection and bypass-select generator for the CP pipeline (IF -> ID -> EX -> WB).
- Compares IF-stage source register indices against the destination of the instruction currently in ID (one cycle ahead).
- Produces the registered bypass-enable and bypass-source-select flags that the CP bypass network consumes while the consumer sits in ID.
- Generates a one-cycle interlock stall when the producer's result is not yet available at the EX bypass point.

Parameters:
- RF_INDEX_WIDTH, 5, register-file index width (`DEF_CP_RF_INDEX_WIDTH).
- MUL_LATENCY, 1, EX cycles before the MUL result is valid on the bypass bus (1 or 2).
- LSU_LATENCY, 2, EX cycles before the LSU result is valid on the bypass bus (1 or 2).
- SHADOW_INDEX, 31, register index aliased to the shadow register.

Ports:
- iClk  in  1  clock.
- iReset_n  in  1  asynchronous active-low reset.
- iStall  in  1  global pipeline stall; all state is held.
- iFlush  in  1  branch flush; kills the instruction in IF.
- iIF_Valid  in  1  IF slot holds a real instruction.
- iIF_RF_Read_Addr_A  in  RF_INDEX_WIDTH  source A index.
- iIF_RF_Read_Addr_B  in  RF_INDEX_WIDTH  source B index.
- iIF_Read_En_A  in  1  instruction reads port A.
- iIF_Read_En_B  in  1  instruction reads port B (0 for immediate-only operand B).
- iIF_Write_En  in  1  instruction writes the RF.
- iIF_RF_Write_Addr  in  RF_INDEX_WIDTH  destination index.
- iIF_Result_Src  in  2  producing unit, `RISC24_CP_BYPASS_SRC_{ALU,MUL,LSU} encoding.
- oIF_BP_Bypass_Read_A  out  1  port A is bypassed (registered).
- oIF_BP_Bypass_Read_B  out  1  port B is bypassed (registered).
- oIF_BP_Bypass_Sel_A  out  2  port A bypass source (registered).
- oIF_BP_Bypass_Sel_B  out  2  port B bypass source (registered).
- oHazard_Stall  out  1  combinational interlock request to IF.
- oID_Write_Valid  out  1  ID slot holds a live register writer.
- oID_RF_Write_Addr  out  RF_INDEX_WIDTH  ID slot destination index.

Behaviour:
- State: ID-slot register {valid, dest, src} plus the four registered bypass outputs.
- Reset (async, iReset_n=0): all outputs and ID slot = 0; Sel = ALU (2'b00).
- Effective source: src_eff = SHADOW if dest == SHADOW_INDEX, else iIF_Result_Src.
- Latency classification: a producer is late when src is MUL with MUL_LATENCY=2, or src is LSU with LSU_LATENCY=2. SHADOW and ALU are never late.
- Match condition X (X in A/B): iIF_Valid & iIF_Read_En_X & ID.valid & (ID.dest == Addr_X) & (Addr_X != 0).
- oHazard_Stall = (matchA | matchB) & late(ID.src) & ~iFlush. The output is combinational and is not gated by iStall.
- Update priority: reset > iFlush > iStall > hazard > normal.
- iFlush at the clock edge: ID slot valid = 0 and all bypass flags = 0. The flushed IF instruction is never loaded.
- iStall (no flush): every register holds its value.
- Hazard (no flush, no stall):
  - ID slot loads a bubble (valid = 0); bypass flags = 0.
  - IF holds, so the consumer is re-presented next cycle.
  - In that next cycle the producer is in WB and the RF internal bypass supplies the data, so no further bypass or stall is generated.
- Normal operation:
  - ID slot <= {iIF_Valid & iIF_Write_En & (iIF_RF_Write_Addr != 0), iIF_RF_Write_Addr, src_eff}.
  - Bypass_Read_X <= matchX; Sel_X <= ID.src when matched, else ALU.
- Writes to r0 never create an ID-slot entry. A read of r0 never bypasses.
- A and B matching the same producer: both bypass with the identical select.
- Bypass flags are valid exactly one cycle after the consumer's IF cycle, aligned with the consumer in ID.
- Back-to-back writers: only the most recent (ID) producer is tracked; older producers are covered by WB forwarding in the bypass network.

Test Plan:
- Reset and idle: reset mid-operation with the ID slot valid and dest=7 -> all outputs 0 immediately, with no clock edge needed. After release, iIF_Valid=0 -> outputs stay 0.
- ALU forward: issue ADD r3 (src ALU), then ADD r5,r3,r3 -> next cycle Bypass_Read_A=1, Bypass_Read_B=1, Sel_A=Sel_B=ALU, oHazard_Stall never 1.
- Load-use (LSU_LATENCY=2): LW r4, then ADD r6,r4,r1 -> oHazard_Stall=1 for exactly one cycle, a bubble in ID (oID_Write_Valid=0), then on re-presentation Bypass_Read_A=0 and stall=0.
- MUL forward (MUL_LATENCY=1) to port B: MUL r9, then SUB r2,r1,r9 -> Bypass_Read_A=0, Bypass_Read_B=1, Sel_B=MUL.
- Shadow and r0: ALU write to r31 then read r31 -> Sel=SHADOW. ALU write to r0 then read r0 -> no bypass, oID_Write_Valid=0.
- Stall, then flush: iStall=1 for 3 cycles after a matching pair -> flags and ID slot held constant throughout. Then iFlush with a matching consumer in IF -> next cycle all flags 0 and ID slot invalid.
